riscv_muldiv_seq: RTL
=====================

Name: riscv_muldiv_seq

Overview:
- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit.
- Sits beside the single-cycle integer ALU in the execute stage; handles all eight M-extension ops.
- Radix-2 iterative datapath (one bit per cycle) behind valid/ready handshakes on both sides.
- Supports pipeline flush and early-out for divide special cases.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- TAG_W, 5, width of pass-through tag (destination register index).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  abort in-flight op, return to IDLE
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request
- in_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_a  in  XLEN  rs1 operand
- in_b  in  XLEN  rs2 operand
- in_tag  in  TAG_W  tag, returned with result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of result

Behaviour:
- Reset: clk edge with rst_n=0 → state IDLE, out_valid=0, out_result=0, out_tag=0, iteration counter=0. in_ready=1 in IDLE.
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready at edge T latches op, operands and tag.
  - Normal case → CALC, counter=XLEN.
  - Special case → DONE directly; out_valid=1 from T+1.
- Special cases, no iteration:
  - DIV/DIVU with b=0 → quotient all-ones; REM/REMU → a.
  - DIV with a=most-negative and b=-1 → quotient a; REM → 0.
- CALC:
  - One shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements.
  - When counter reaches 1, the next edge completes the last step → DONE.
  - Normal latency: accept at T → out_valid=1 at T+XLEN+1. Result and out_tag are registered.
- Multiply:
  - Signed operands converted to magnitude before iteration; 2XLEN product negated at end if signs differ.
  - MULHSU: a signed, b unsigned.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
  - Sign fix-up is folded into the last CALC cycle; no extra cycle.
- Divide:
  - Magnitudes used for DIV/REM.
  - Quotient negated if operand signs differ.
  - Remainder takes the sign of a.
- DONE:
  - out_valid, out_result and out_tag held stable until out_ready=1.
  - Handshake edge → IDLE; in_ready=1 the following cycle (no same-cycle back-to-back accept).
- flush:
  - Highest priority after reset: any state → IDLE next edge; out_valid=0.
  - A request presented in the same cycle is not accepted.
- Reset or flush mid-CALC discards the operation; no result is ever emitted for it.
- in_valid while in_ready=0 has no effect; the requester holds.
- Inputs are ignored outside the accept edge; operand changes during CALC do not affect the result.

Test Plan:
- XLEN=32, MUL a=0x0000_0007 b=0xFFFF_FFFD → out_result=0xFFFF_FFEB at T+33; MULH same operands → 0xFFFF_FFFF; MULHU → 0x0000_0006.
- DIV a=-7 b=2 → 0xFFFF_FFFD (-3); REM → 0xFFFF_FFFF (-1); DIVU a=0xFFFF_FFFF b=0x10 → 0x0FFF_FFFF. All at T+33.
- DIVU a=5 b=0 → 0xFFFF_FFFF; REMU → 5; DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000, REM → 0. All at T+1; in_ready=0 until handshake.
- Backpressure: out_ready=0 for 10 cycles after completion → result and tag (e.g. 0x1A) stable; in_ready=0 throughout; in_ready=1 one cycle after out_ready=1.
- flush asserted at cycle 10 of CALC → out_valid never rises; IDLE next edge. New MULHSU a=-1 b=2 → 0xFFFF_FFFF at T+33.
- rst_n=0 mid-CALC with out_ready=1 → all outputs 0, in_ready=1 after reset deasserts. XLEN=64 regression: MULHU 0xFFFF_FFFF_FFFF_FFFF² → 0xFFFF_FFFF_FFFF_FFFE at T+65.

Source files
------------

// File: rtl/riscv_muldiv_seq.sv
// Radix-2 sequential RV32M/RV64M multiply/divide unit.
// Valid/ready on both sides, flush abort, early-out for divide special cases.
module riscv_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mc;
    logic            negp;
    logic            nega;

    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic            is_div, dz, ovf;
    logic [XLEN-1:0] ma, mb, spec;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   sh;
    logic [XLEN-1:0] sub;
    logic            ge;
    logic [XLEN-1:0] nhi, nlo;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rem, fin;

    assign in_ready = (state == IDLE);

    always_comb begin
        a_sgn  = (in_op == 3'b001) || (in_op == 3'b010) ||
                 (in_op == 3'b100) || (in_op == 3'b110);
        b_sgn  = (in_op == 3'b001) || (in_op == 3'b100) ||
                 (in_op == 3'b110);
        a_neg  = a_sgn & in_a[XLEN-1];
        b_neg  = b_sgn & in_b[XLEN-1];
        ma     = a_neg ? -in_a : in_a;
        mb     = b_neg ? -in_b : in_b;
        is_div = in_op[2];
        dz     = is_div && (in_b == '0);
        ovf    = is_div && !in_op[0] && (&in_b) &&
                 (in_a == {1'b1, {(XLEN-1){1'b0}}});
        if (dz)
            spec = in_op[1] ? in_a : '1;
        else
            spec = in_op[1] ? '0 : in_a;
    end

    // One iteration step; hi/lo hold product or remainder/quotient
    always_comb begin
        sum  = {1'b0, hi} + {1'b0, (lo[0] ? mc : {XLEN{1'b0}})};
        sh   = {hi, lo[XLEN-1]};
        ge   = (sh >= {1'b0, mc});
        sub  = sh[XLEN-1:0] - mc;
        if (op_q[2]) begin
            nhi = ge ? sub : sh[XLEN-1:0];
            nlo = {lo[XLEN-2:0], ge};
        end else begin
            nhi = sum[XLEN:1];
            nlo = {sum[0], lo[XLEN-1:1]};
        end
        prod = {nhi, nlo};
        if (negp)
            prod = -prod;
        quo = negp ? -nlo : nlo;
        rem = nega ? -nhi : nhi;
        if (op_q[2])
            fin = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 2'b00)
            fin = prod[XLEN-1:0];
        else
            fin = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            hi         <= '0;
            lo         <= '0;
            mc         <= '0;
            negp       <= 1'b0;
            nega       <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        out_tag <= in_tag;
                        if (dz || ovf) begin
                            out_result <= spec;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            hi    <= '0;
                            lo    <= is_div ? ma : mb;
                            mc    <= is_div ? mb : ma;
                            negp  <= a_neg ^ b_neg;
                            nega  <= a_neg;
                            cnt   <= CW'(XLEN);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi  <= nhi;
                    lo  <= nlo;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        out_result <= fin;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
